// File: rtl/cu_pkg.sv
// Shared definitions for the parametrised computational unit: ALU function
// codes, multiplier FSM states and the data_bus source-code layout.
package cu_pkg;

  localparam logic [2:0] FN_NEG  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_ADD  = 3'b010;
  localparam logic [2:0] FN_MULH = 3'b011;
  localparam logic [2:0] FN_MULL = 3'b100;
  localparam logic [2:0] FN_XOR  = 3'b101;
  localparam logic [2:0] FN_AND  = 3'b110;
  localparam logic [2:0] FN_NOT  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

  // Slots that follow the X and Y registers on the source map.
  localparam int SRC_R    = 0;
  localparam int SRC_M    = 1;
  localparam int SRC_I    = 2;
  localparam int SRC_DM   = 3;
  localparam int SRC_PM   = 4;
  localparam int SRC_PINS = 5;

  function automatic int src_code(input int nx, input int ny, input int slot);
    return nx + ny + slot;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, DW steps, then a DONE cycle.
// busy is high from the cycle after start until the DONE cycle completes; start is ignored while busy.
module seq_multiplier
  import cu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW + 1);

  mul_state_t      state_q, state_d;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] a_sh;
  logic [DW-1:0]   b_sh;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            a_sh <= {{DW{1'b0}}, a};
            b_sh <= b;
            cnt  <= CW'(DW);
          end
        end
        MUL: begin
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (cnt == CW'(1)) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = acc;

endmodule

// File: rtl/param_computational_unit.sv
// Datapath register file + ALU with a sequential multiplier; single-cycle ops write r on the next edge.
// Multiplies hold busy for DW+1 cycles, during which every load enable is ignored.
module param_computational_unit
  import cu_pkg::*;
#(
  parameter int DW    = 4,
  parameter int NX    = 2,
  parameter int NY    = 2,
  parameter int SRC_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          i_pins,
  input  logic [DW-1:0]          dm,
  input  logic [3:0]             ir_nibble,
  input  logic [SRC_W-1:0]       source_sel,
  input  logic [$clog2(NX)-1:0]  x_sel,
  input  logic [$clog2(NY)-1:0]  y_sel,
  input  logic                   i_sel,
  input  logic [NX-1:0]          x_en,
  input  logic [NY-1:0]          y_en,
  input  logic                   r_en,
  input  logic                   m_en,
  input  logic                   i_en,
  input  logic                   o_en,
  output logic [DW-1:0]          data_bus,
  output logic [DW-1:0]          r,
  output logic [DW-1:0]          m,
  output logic [DW-1:0]          i,
  output logic [DW-1:0]          o_reg,
  output logic [2*DW-1:0]        from_CU,
  output logic                   r_eq_0,
  output logic                   r_carry,
  output logic                   busy
);

  localparam int XSW = $clog2(NX);
  localparam int YSW = $clog2(NY);

  logic [DW-1:0]   x_q [NX];
  logic [DW-1:0]   y_q [NY];
  logic [DW-1:0]   pm_data;
  logic [DW-1:0]   alu_x, alu_y, alu_res, mul_res;
  logic [DW:0]     ext;
  logic            alu_c;
  logic [2:0]      fn;
  logic            h;
  logic            fn_is_mul, mul_start, mul_done, mul_hi;
  logic [2*DW-1:0] product;

  assign fn        = ir_nibble[2:0];
  assign h         = ir_nibble[3];
  assign pm_data   = DW'(ir_nibble);
  assign fn_is_mul = (fn == FN_MULH) || (fn == FN_MULL);
  assign mul_start = r_en && fn_is_mul && !busy;
  assign from_CU   = {x_q[1], x_q[0]};
  assign mul_res   = mul_hi ? product[2*DW-1:DW] : product[DW-1:0];

  always_comb begin
    data_bus = '0;
    for (int k = 0; k < NX; k++)
      if (source_sel == SRC_W'(k)) data_bus = x_q[k];
    for (int k = 0; k < NY; k++)
      if (source_sel == SRC_W'(NX + k)) data_bus = y_q[k];
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_R)))    data_bus = r;
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_M)))    data_bus = m;
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_I)))    data_bus = i;
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_DM)))   data_bus = dm;
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_PM)))   data_bus = pm_data;
    if (source_sel == SRC_W'(src_code(NX, NY, SRC_PINS))) data_bus = i_pins;
  end

  // Out-of-range selects fall through to register 0.
  always_comb begin
    alu_x = x_q[0];
    alu_y = y_q[0];
    for (int k = 1; k < NX; k++)
      if (x_sel == XSW'(k)) alu_x = x_q[k];
    for (int k = 1; k < NY; k++)
      if (y_sel == YSW'(k)) alu_y = y_q[k];
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    ext     = '0;
    case (fn)
      FN_NEG:  alu_res = h ? r : -alu_x;
      FN_SUB: begin
        ext     = {1'b0, alu_x} - {1'b0, alu_y};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
      end
      FN_ADD: begin
        ext     = {1'b0, alu_x} + {1'b0, alu_y};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
      end
      FN_XOR:  alu_res = alu_x ^ alu_y;
      FN_AND:  alu_res = alu_x & alu_y;
      FN_NOT:  alu_res = h ? r : ~alu_x;
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(.DW(DW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (alu_x),
    .b       (alu_y),
    .busy    (busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NX; k++) x_q[k] <= '0;
      for (int k = 0; k < NY; k++) y_q[k] <= '0;
      r       <= '0;
      m       <= '0;
      i       <= '0;
      o_reg   <= '0;
      r_eq_0  <= 1'b1;
      r_carry <= 1'b0;
      mul_hi  <= 1'b0;
    end else if (mul_done) begin
      r      <= mul_res;
      r_eq_0 <= (mul_res == '0);
    end else if (!busy) begin
      for (int k = 0; k < NX; k++)
        if (x_en[k]) x_q[k] <= data_bus;
      for (int k = 0; k < NY; k++)
        if (y_en[k]) y_q[k] <= data_bus;
      if (r_en) begin
        if (fn_is_mul) begin
          mul_hi <= (fn == FN_MULH);
        end else begin
          r      <= alu_res;
          r_eq_0 <= (alu_res == '0);
          if (fn == FN_ADD || fn == FN_SUB) r_carry <= alu_c;
        end
      end
      if (m_en) m <= data_bus;
      if (i_en) i <= i_sel ? i + m : data_bus;
      if (o_en) o_reg <= data_bus;
    end
  end

endmodule

// File: tb/tb_param_computational_unit.sv
// Bench: directed scenarios plus random instruction streams against an arithmetic reference model;
// a second instance (NX=4, NY=3) covers the wider source map.
module tb_param_computational_unit;

  localparam int DW   = 4;
  localparam int MASK = (1 << DW) - 1;
  localparam int PM1  = 2 + 2 + 4;
  localparam int PM2  = 4 + 3 + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [3:0] i_pins, dm, ir_nibble, source_sel;
  logic       x_sel, y_sel, i_sel, r_en, m_en, i_en, o_en;
  logic [1:0] x_en, y_en;
  logic [3:0] data_bus, r, m, i, o_reg;
  logic [7:0] from_CU;
  logic       r_eq_0, r_carry, busy;

  logic [3:0] b_i_pins, b_dm, b_ir_nibble, b_source_sel;
  logic [1:0] b_x_sel, b_y_sel;
  logic       b_i_sel, b_r_en, b_m_en, b_i_en, b_o_en;
  logic [3:0] b_x_en;
  logic [2:0] b_y_en;
  logic [3:0] b_data_bus, b_r, b_m, b_i, b_o_reg;
  logic [7:0] b_from_CU;
  logic       b_r_eq_0, b_r_carry, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  int mx[2], my[2];
  int mr, mm, mi, mo, mz, mc, mcnt, mres;

  param_computational_unit u_dut (
    .clk(clk), .reset(reset), .i_pins(i_pins), .dm(dm), .ir_nibble(ir_nibble),
    .source_sel(source_sel), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
    .x_en(x_en), .y_en(y_en), .r_en(r_en), .m_en(m_en), .i_en(i_en), .o_en(o_en),
    .data_bus(data_bus), .r(r), .m(m), .i(i), .o_reg(o_reg), .from_CU(from_CU),
    .r_eq_0(r_eq_0), .r_carry(r_carry), .busy(busy)
  );

  param_computational_unit #(.DW(4), .NX(4), .NY(3), .SRC_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .i_pins(b_i_pins), .dm(b_dm), .ir_nibble(b_ir_nibble),
    .source_sel(b_source_sel), .x_sel(b_x_sel), .y_sel(b_y_sel), .i_sel(b_i_sel),
    .x_en(b_x_en), .y_en(b_y_en), .r_en(b_r_en), .m_en(b_m_en), .i_en(b_i_en), .o_en(b_o_en),
    .data_bus(b_data_bus), .r(b_r), .m(b_m), .i(b_i), .o_reg(b_o_reg), .from_CU(b_from_CU),
    .r_eq_0(b_r_eq_0), .r_carry(b_r_carry), .busy(b_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_bus(input int sel);
    if (sel < 2) return mx[sel];
    if (sel < 4) return my[sel - 2];
    case (sel - 4)
      0: return mr;
      1: return mm;
      2: return mi;
      3: return int'(dm);
      4: return int'(ir_nibble);
      5: return int'(i_pins);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mx[0] = 0; mx[1] = 0; my[0] = 0; my[1] = 0;
    mr = 0; mm = 0; mi = 0; mo = 0; mz = 1; mc = 0; mcnt = 0; mres = 0;
  endtask

  task automatic clear_in();
    source_sel = '0; ir_nibble = '0; x_sel = 0; y_sel = 0; i_sel = 0;
    x_en = '0; y_en = '0; r_en = 0; m_en = 0; i_en = 0; o_en = 0;
  endtask

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic cycle();
    int bus, xv, yv, res, fn, h;
    #1;
    bus = model_bus(int'(source_sel));
    chk("data_bus", data_bus, bus);
    xv = mx[x_sel];
    yv = my[y_sel];
    fn = int'(ir_nibble[2:0]);
    h  = int'(ir_nibble[3]);
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mr = mres;
        mz = (mr == 0);
      end
    end else begin
      if (r_en) begin
        res = -1;
        case (fn)
          0: res = h ? mr : ((-xv) & MASK);
          1: begin res = (xv - yv) & MASK; mc = (xv < yv); end
          2: begin res = (xv + yv) & MASK; mc = ((xv + yv) > MASK); end
          3: begin mres = (xv * yv) >> DW; mcnt = DW + 1; end
          4: begin mres = (xv * yv) & MASK; mcnt = DW + 1; end
          5: res = xv ^ yv;
          6: res = xv & yv;
          default: res = h ? mr : ((~xv) & MASK);
        endcase
        if (res >= 0) begin
          mr = res;
          mz = (res == 0);
        end
      end
      if (x_en[0]) mx[0] = bus;
      if (x_en[1]) mx[1] = bus;
      if (y_en[0]) my[0] = bus;
      if (y_en[1]) my[1] = bus;
      if (i_en) mi = i_sel ? ((mi + mm) & MASK) : bus;
      if (m_en) mm = bus;
      if (o_en) mo = bus;
    end
    @(posedge clk);
    @(negedge clk);
    chk("r", r, mr);
    chk("r_eq_0", r_eq_0, mz);
    chk("r_carry", r_carry, mc);
    chk("m", m, mm);
    chk("i", i, mi);
    chk("o_reg", o_reg, mo);
    chk("busy", busy, (mcnt > 0));
    chk("from_CU", from_CU, (mx[1] << DW) | mx[0]);
  endtask

  task automatic pm_load(input logic [1:0] xe, input logic [1:0] ye,
                         input logic me, input logic ie, input logic [3:0] v);
    clear_in();
    source_sel = PM1[3:0];
    ir_nibble = v;
    x_en = xe; y_en = ye; m_en = me; i_en = ie;
    cycle();
  endtask

  task automatic alu_op(input logic [3:0] nib);
    clear_in();
    ir_nibble = nib;
    r_en = 1;
    cycle();
    clear_in();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
  endtask

  task automatic b_clear();
    b_i_pins = '0; b_dm = '0; b_ir_nibble = '0; b_source_sel = '0; b_x_sel = '0; b_y_sel = '0;
    b_i_sel = 0; b_x_en = '0; b_y_en = '0; b_r_en = 0; b_m_en = 0; b_i_en = 0; b_o_en = 0;
  endtask

  task automatic b_pm_load(input logic [3:0] xe, input logic [2:0] ye,
                           input logic me, input logic ie, input logic [3:0] v);
    b_clear();
    b_source_sel = PM2[3:0];
    b_ir_nibble = v;
    b_x_en = xe; b_y_en = ye; b_m_en = me; b_i_en = ie;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int exp2[16];
    exp2 = '{1, 2, 3, 4, 5, 6, 7, 7, 9, 10, 12, 11, 13, 0, 0, 0};
    clear_in();
    b_clear();
    dm = 4'h6; i_pins = 4'h9;
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_r", r, 0);
    chk("rst_r_eq_0", r_eq_0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_from_CU", from_CU, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // add: 3+5 and 0xF+1
    pm_load(2'b01, 2'b00, 0, 0, 4'h3);
    pm_load(2'b00, 2'b01, 0, 0, 4'h5);
    alu_op(4'b0010);
    chk("add_r", r, 8);
    chk("add_carry", r_carry, 0);
    chk("add_z", r_eq_0, 0);
    pm_load(2'b01, 2'b00, 0, 0, 4'hF);
    pm_load(2'b00, 2'b01, 0, 0, 4'h1);
    alu_op(4'b0010);
    chk("wrap_r", r, 0);
    chk("wrap_carry", r_carry, 1);
    chk("wrap_z", r_eq_0, 1);

    // multiply 0xD * 0xB = 143
    pm_load(2'b01, 2'b00, 0, 0, 4'hD);
    pm_load(2'b00, 2'b01, 0, 0, 4'hB);
    alu_op(4'b0100);
    wait_idle(n);
    chk("mull_busy_cycles", n, 5);
    chk("mull_r", r, 4'hF);
    alu_op(4'b0011);
    wait_idle(n);
    chk("mulh_busy_cycles", n, 5);
    chk("mulh_r", r, 4'h8);

    // loads ignored while busy
    alu_op(4'b0100);
    pm_load(2'b01, 2'b00, 0, 0, 4'h7);
    chk("busy_x0_hold", from_CU[3:0], 4'hD);
    clear_in();
    wait_idle(n);
    pm_load(2'b01, 2'b00, 0, 0, 4'h7);
    chk("idle_x0_load", from_CU[3:0], 4'h7);

    // i stepping with wrap
    pm_load(2'b00, 2'b00, 1, 0, 4'h3);
    pm_load(2'b00, 2'b00, 0, 1, 4'hE);
    clear_in();
    i_sel = 1; i_en = 1;
    cycle();
    chk("i_step1", i, 4'h1);
    cycle();
    chk("i_step2", i, 4'h4);

    // asynchronous reset in the middle of a multiply
    pm_load(2'b01, 2'b00, 0, 0, 4'h5);
    alu_op(4'b0100);
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("arst_r", r, 0);
    chk("arst_r_eq_0", r_eq_0, 1);
    chk("arst_busy", busy, 0);
    chk("arst_i", i, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // wide instance: out-of-range y_sel and source map sweep
    for (int k = 0; k < 4; k++) b_pm_load(4'(1 << k), 3'b000, 0, 0, 4'(k + 1));
    for (int k = 0; k < 3; k++) b_pm_load(4'b0000, 3'(1 << k), 0, 0, 4'(k + 5));
    b_clear();
    b_ir_nibble = 4'b0010; b_x_sel = 2'd1; b_y_sel = 2'd3; b_r_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("oor_ysel_add", b_r, 7);
    b_pm_load(4'b0000, 3'b000, 1, 0, 4'h9);
    b_pm_load(4'b0000, 3'b000, 0, 1, 4'hA);
    b_clear();
    b_dm = 4'hC; b_i_pins = 4'hD; b_ir_nibble = 4'hB;
    for (int s = 0; s < 16; s++) begin
      b_source_sel = 4'(s);
      #1 chk($sformatf("sweep%0d", s), b_data_bus, exp2[s]);
    end
    b_clear();

    // random instruction stream
    repeat (600) begin
      source_sel = 4'($urandom_range(0, 15));
      ir_nibble  = 4'($urandom);
      dm         = 4'($urandom);
      i_pins     = 4'($urandom);
      x_sel      = 1'($urandom);
      y_sel      = 1'($urandom);
      i_sel      = 1'($urandom);
      x_en       = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      y_en       = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      r_en       = 1'($urandom);
      m_en       = ($urandom_range(0, 3) == 0);
      i_en       = ($urandom_range(0, 3) == 0);
      o_en       = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
